dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter ADDR_BITS, default 6: word-index width; memory holds 2^ADDR_BITS 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states per access, legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MemReq  input  1  request strobe from processor load/store path.
REQ-006 MemWE  input  1  1 = write request, 0 = read request; sampled with MemReq.
REQ-007 Addr  input  32  byte address of access (processor ALUResult).
REQ-008 WriteData  input  32  store data; sampled with MemReq.
REQ-009 ReadData  output  32  registered load data.
REQ-010 MemReady  output  1  one-cycle response pulse.
REQ-011 MemErr  output  1  error flag, valid only while MemReady=1.
REQ-012 MemBusy  output  1  high whenever state is not IDLE.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-014 IDLE: MemReq=1 at a rising edge SHALL latch MemWE, Addr, WriteData and go to WAIT (WAIT_CYCLES>0) or directly to RESP (WAIT_CYCLES=0).
REQ-015 WAIT: a 4-bit counter loaded with WAIT_CYCLES-1 on entry SHALL decrement each edge; at count 0 the next edge moves to RESP, so WAIT lasts exactly WAIT_CYCLES cycles.
REQ-016 RESP: state lasts exactly one cycle, MemReady=1, then returns to IDLE unconditionally.
REQ-017 Latency: request sampled at edge of cycle t SHALL produce MemReady=1 during cycle t+WAIT_CYCLES+1; minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-018 MemReq in WAIT or RESP SHALL be ignored; no queuing; inputs need not be held after acceptance.
REQ-019 Word index = latched Addr[ADDR_BITS+1:2].
REQ-020 Error when latched Addr[1:0]!=0 (misaligned) or any of Addr[31:ADDR_BITS+2] nonzero (out of range).
REQ-021 Valid write: word SHALL be written at the edge entering RESP; ReadData unchanged; MemErr=0.
REQ-022 Valid read: ReadData SHALL be loaded from the addressed word at the edge entering RESP; MemErr=0.
REQ-023 Errored access: no memory write; ReadData set to 0 for reads, unchanged for writes; MemErr=1 during RESP.
REQ-024 ReadData SHALL hold its value between responses.
REQ-025 MemErr SHALL be 0 whenever MemReady=0.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, counter 0, ReadData=0, MemReady=0, MemErr=0, MemBusy=0, and all memory words to 0.
REQ-027 Reset during WAIT or RESP SHALL abort the access: no write committed, no MemReady pulse.
REQ-028 Following deassertion, the first rising edge with MemReq=1 SHALL be accepted normally.

Verification (WAIT_CYCLES=2, ADDR_BITS=6)
REQ-029 After reset, read 0x00 sampled at cycle 0 -> MemReady=1 only in cycle 3, ReadData=0, MemErr=0, MemBusy=1 in cycles 1-3.
REQ-030 Write 0x10 = 0xDEADBEEF, then read 0x10 -> ReadData=0xDEADBEEF, MemErr=0.
REQ-031 Write 0xFC = 0x12345678, read 0xFC -> 0x12345678; read 0x100 -> MemErr=1, ReadData=0.
REQ-032 Write 0x12 = 0xFFFFFFFF (misaligned) -> MemErr=1; subsequent read 0x10 still 0xDEADBEEF.
REQ-033 MemReq held high with changing Addr through WAIT/RESP -> only the first and the next IDLE-sampled requests served, one MemReady per accepted request.
REQ-034 Write 0x20 = 0xA5A5A5A5 with reset pulsed in WAIT -> no MemReady; subsequent read 0x20 returns 0.

Source files
------------

// File: rtl/dmem_resp.sv
// dmem_resp: single-port word memory with a fixed wait-state response handshake
module dmem_resp #(
    parameter int ADDR_BITS   = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWE,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr,
    output logic        MemBusy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam int         WORDS    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [31:0]          mem_q [WORDS];
    logic [31:0]          mem_d [WORDS];
    logic                 acc_we;
    logic [31:0]          acc_addr;
    logic [31:0]          acc_wdata;
    logic                 acc_err;
    logic [ADDR_BITS-1:0] acc_idx;

    // Next-state logic; the access commits on the edge that enters RESP, using live inputs when there are no wait states
    always_comb begin
        acc_we    = (state_q == S_IDLE) ? MemWE : we_q;
        acc_addr  = (state_q == S_IDLE) ? Addr : addr_q;
        acc_wdata = (state_q == S_IDLE) ? WriteData : wdata_q;
        acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_BITS + 2)) != 32'd0);
        acc_idx   = acc_addr[ADDR_BITS+1:2];
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_d     = mem_q;
        case (state_q)
            S_IDLE: if (MemReq) begin
                we_d    = MemWE;
                addr_d  = Addr;
                wdata_d = WriteData;
                state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                cnt_d   = CNT_LOAD;
            end
            S_WAIT: begin
                state_d = (cnt_q == 4'd0) ? S_RESP : S_WAIT;
                cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_RESP) begin
            err_d = acc_err;
            if (!acc_we)
                rdata_d = acc_err ? 32'd0 : mem_q[acc_idx];
            else if (!acc_err)
                mem_d[acc_idx] = acc_wdata;
        end
    end

    // State, latched request, response data and memory array, all cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < WORDS; i++) mem_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    assign ReadData = rdata_q;
    assign MemReady = (state_q == S_RESP);
    assign MemErr   = MemReady & err_q;
    assign MemBusy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed vector bench for dmem_resp at WAIT_CYCLES=2, ADDR_BITS=6
module tb_dmem_resp;
    logic        clk;
    logic        reset;
    logic        MemReq;
    logic        MemWE;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        MemErr;
    logic        MemBusy;

    int nvec = 0;
    int nmis = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t vt [0:13];

    dmem_resp #(.ADDR_BITS(6), .WAIT_CYCLES(2)) dut (
        .clk(clk),
        .reset(reset),
        .MemReq(MemReq),
        .MemWE(MemWE),
        .Addr(Addr),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .MemReady(MemReady),
        .MemErr(MemErr),
        .MemBusy(MemBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Starts at a negedge, issues one request, checks the full 4-cycle response window, ends at a negedge
    task automatic access(input string nm, input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input logic err);
        MemReq    = 1'b1;
        MemWE     = we;
        Addr      = a;
        WriteData = wd;
        @(posedge clk);
        #1;
        MemReq    = 1'b0;
        MemWE     = ~we;
        Addr      = 32'hFFFF_FFF3;
        WriteData = 32'h5555_AAAA;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("%s/busy%0d", nm, k), 32'(MemBusy), 32'd1);
            chk($sformatf("%s/ready%0d", nm, k), 32'(MemReady), 32'(k == 3));
            if (k == 3) begin
                chk($sformatf("%s/rdata", nm), ReadData, rd);
                chk($sformatf("%s/err", nm), 32'(MemErr), 32'(err));
            end else begin
                chk($sformatf("%s/err%0d", nm, k), 32'(MemErr), 32'd0);
            end
        end
        @(negedge clk);
        chk($sformatf("%s/idle_ready", nm), 32'(MemReady), 32'd0);
        chk($sformatf("%s/idle_busy", nm), 32'(MemBusy), 32'd0);
        chk($sformatf("%s/hold_rdata", nm), ReadData, rd);
    endtask

    initial begin
        vt[0]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
        vt[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vt[2]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[3]  = '{1'b1, 32'h0000_00FC, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
        vt[4]  = '{1'b0, 32'h0000_00FC, 32'h0,         32'h1234_5678, 1'b0};
        vt[5]  = '{1'b0, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1};
        vt[6]  = '{1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vt[7]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[8]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1};
        vt[9]  = '{1'b1, 32'h0000_0004, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
        vt[10] = '{1'b0, 32'h0000_0004, 32'h0,         32'h0BAD_F00D, 1'b0};
        vt[11] = '{1'b1, 32'h8000_0004, 32'h0000_0001, 32'h0BAD_F00D, 1'b1};
        vt[12] = '{1'b0, 32'h0000_0004, 32'h0,         32'h0BAD_F00D, 1'b0};
        vt[13] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};

        reset = 1'b1; MemReq = 1'b0; MemWE = 1'b0; Addr = 32'd0; WriteData = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst/rdata", ReadData, 32'd0);
        chk("rst/ready", 32'(MemReady), 32'd0);
        chk("rst/err", 32'(MemErr), 32'd0);
        chk("rst/busy", 32'(MemBusy), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++)
            access($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rd, vt[i].err);

        // MemReq held high: only the first and the next IDLE-sampled request are served
        MemReq = 1'b1; MemWE = 1'b0; Addr = 32'h0000_0010;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("hold/ready%0d", c), 32'(MemReady), 32'(c == 3 || c == 7));
            chk($sformatf("hold/busy%0d", c), 32'(MemBusy), 32'(c != 4 && c != 8));
            if (c == 3) chk("hold/rdata1", ReadData, 32'hDEAD_BEEF);
            if (c == 7) chk("hold/rdata2", ReadData, 32'h0BAD_F00D);
            Addr = (c == 4) ? 32'h0000_0004 : 32'h0000_00FC;
            if (c == 7) MemReq = 1'b0;
        end

        // Reset pulsed in WAIT aborts the write and clears memory and ReadData
        MemReq = 1'b1; MemWE = 1'b1; Addr = 32'h0000_0020; WriteData = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        MemReq = 1'b0;
        @(negedge clk);
        chk("abort/busy_pre", 32'(MemBusy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort/busy_async", 32'(MemBusy), 32'd0);
        chk("abort/rdata_async", ReadData, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort/ready%0d", c), 32'(MemReady), 32'd0);
        end
        access("abort/rd20", 1'b0, 32'h0000_0020, 32'h0, 32'h0, 1'b0);
        access("abort/rd10", 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
